// File: rtl/clkdiv_meas_if.sv
// Bus between clkdiv_meas and its user: measurement control in,
// period/high-time results and status flags out.
interface clkdiv_meas_if #(
    parameter int W = 12
);
    logic         en;
    logic         sig_in;
    logic [W-1:0] period;
    logic [W-1:0] high_cnt;
    logic         meas_stb;
    logic         valid;
    logic         stable;
    logic         timeout;

    modport master (
        output en, sig_in,
        input  period, high_cnt, meas_stb, valid, stable, timeout
    );

    modport slave (
        input  en, sig_in,
        output period, high_cnt, meas_stb, valid, stable, timeout
    );
endinterface

// File: rtl/clkdiv_meas.sv
// Measures period and high time of a slow asynchronous square wave
// in clk cycles, with lock, stability and timeout reporting.
module clkdiv_meas #(
    parameter int W       = 12,
    parameter int TIMEOUT = 4095
) (
    input  logic           clk,
    input  logic           rst_n,
    clkdiv_meas_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        LOCKED
    } state_t;

    localparam logic [W-1:0] CNT_MAX = W'(TIMEOUT - 1);

    state_t       state;
    logic         s0, s1, s2;
    logic         rise;
    logic [W-1:0] cnt;
    logic [W-1:0] hcnt;
    logic [W-1:0] cnt_inc;
    logic [W-1:0] hcnt_inc;
    logic [W-1:0] period;
    logic [W-1:0] high_cnt;
    logic         meas_stb;
    logic         valid;
    logic         stable;
    logic         timeout;

    // s0/s1 resolve metastability; s2 is only the edge-detect delay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s0 <= bus.sig_in;
            s1 <= s0;
            s2 <= s1;
        end
    end

    assign rise     = s1 & ~s2;
    assign cnt_inc  = cnt + W'(1);
    assign hcnt_inc = hcnt + W'(s1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            hcnt     <= '0;
            period   <= '0;
            high_cnt <= '0;
            meas_stb <= 1'b0;
            valid    <= 1'b0;
            stable   <= 1'b0;
            timeout  <= 1'b0;
        end else if (!bus.en) begin
            state    <= IDLE;
            cnt      <= '0;
            hcnt     <= '0;
            meas_stb <= 1'b0;
            valid    <= 1'b0;
            stable   <= 1'b0;
        end else begin
            meas_stb <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rise) begin
                        state <= ARMED;
                        hcnt  <= W'(1);
                    end else begin
                        hcnt  <= '0;
                    end
                end
                ARMED, LOCKED: begin
                    if (rise) begin
                        state    <= LOCKED;
                        cnt      <= '0;
                        hcnt     <= W'(1);
                        period   <= cnt_inc;
                        high_cnt <= hcnt;
                        meas_stb <= 1'b1;
                        valid    <= 1'b1;
                        timeout  <= 1'b0;
                        stable   <= (state == LOCKED) && (cnt_inc == period);
                    end else if (cnt == CNT_MAX) begin
                        // period/high_cnt keep the last good result
                        state    <= IDLE;
                        cnt      <= '0;
                        hcnt     <= '0;
                        timeout  <= 1'b1;
                        valid    <= 1'b0;
                        stable   <= 1'b0;
                    end else begin
                        cnt      <= cnt_inc;
                        hcnt     <= hcnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    hcnt  <= '0;
                end
            endcase
        end
    end

    assign bus.period   = period;
    assign bus.high_cnt = high_cnt;
    assign bus.meas_stb = meas_stb;
    assign bus.valid    = valid;
    assign bus.stable   = stable;
    assign bus.timeout  = timeout;
endmodule

// File: tb/tb_clkdiv_meas.sv
// Directed bench for clkdiv_meas: periodic waveforms with known
// period/duty, timeout, enable drop and async reset recovery.
module tb_clkdiv_meas;
    logic clk;
    logic rst_n;

    clkdiv_meas_if #(.W(12)) bus ();

    clkdiv_meas #(
        .W(12),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int tcount = 0;
    int stb_n = 0;
    int stb_tick = -1;
    int to_tick = -1;
    int dbl = 0;
    int hi = 2;
    int lo = 2;
    int ph = 0;
    int t0 = 0;
    logic prev_stb = 1'b0;
    logic prev_to = 1'b0;

    // one clock; observe outputs 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        tcount++;
        if (bus.meas_stb) begin
            stb_n++;
            stb_tick = tcount;
            if (prev_stb) dbl++;
        end
        if (bus.timeout && !prev_to) to_tick = tcount;
        prev_stb = bus.meas_stb;
        prev_to = bus.timeout;
    endtask

    task automatic drive(input int n);
        for (int i = 0; i < n; i++) begin
            bus.sig_in = (ph < hi);
            tick();
            ph = (ph + 1) % (hi + lo);
        end
    endtask

    task automatic do_reset();
        bus.sig_in = 1'b0;
        bus.en = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b1;
        stb_n = 0;
        ph = 0;
        to_tick = -1;
        t0 = tcount;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.en = 1'b1;
        hi = 1;
        lo = 1;
        ph = 0;
        drive(6);
        checks++;
        if (bus.period !== 12'd0) begin
            errors++;
            $display("FAIL rst_period: got %0d want 0", bus.period);
        end
        checks++;
        if (bus.high_cnt !== 12'd0) begin
            errors++;
            $display("FAIL rst_high: got %0d want 0", bus.high_cnt);
        end
        checks++;
        if (bus.meas_stb !== 1'b0) begin
            errors++;
            $display("FAIL rst_stb: got %0b want 0", bus.meas_stb);
        end
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid: got %0b want 0", bus.valid);
        end
        checks++;
        if (bus.stable !== 1'b0) begin
            errors++;
            $display("FAIL rst_stable: got %0b want 0", bus.stable);
        end
        checks++;
        if (bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL rst_timeout: got %0b want 0", bus.timeout);
        end
        bus.sig_in = 1'b0;
        #2 rst_n = 1'b1;
        stb_n = 0;
        hi = 2;
        lo = 2;
        ph = 0;
        t0 = tcount;
        drive(6);
        checks++;
        if (stb_n !== 0) begin
            errors++;
            $display("FAIL rst_one_edge: stb %0d want 0", stb_n);
        end
        drive(1);
        checks++;
        if (stb_n !== 1 || stb_tick - t0 !== 7) begin
            errors++;
            $display("FAIL rst_two_edge: stb %0d at %0d want 1 at 7",
                     stb_n, stb_tick - t0);
        end
    endtask

    task automatic test_div4();
        do_reset();
        hi = 2;
        lo = 2;
        drive(7);
        checks++;
        if (stb_n !== 1 || stb_tick - t0 !== 7) begin
            errors++;
            $display("FAIL div4_latency: stb %0d at %0d want 1 at 7",
                     stb_n, stb_tick - t0);
        end
        checks++;
        if (bus.period !== 12'd4 || bus.high_cnt !== 12'd2) begin
            errors++;
            $display("FAIL div4_first: got %0d/%0d want 4/2",
                     bus.period, bus.high_cnt);
        end
        checks++;
        if (bus.valid !== 1'b1 || bus.stable !== 1'b0) begin
            errors++;
            $display("FAIL div4_flags: valid %0b stable %0b want 1 0",
                     bus.valid, bus.stable);
        end
        drive(4);
        checks++;
        if (stb_n !== 2 || bus.stable !== 1'b1 || bus.period !== 12'd4) begin
            errors++;
            $display("FAIL div4_stable: stb %0d stable %0b per %0d want 2 1 4",
                     stb_n, bus.stable, bus.period);
        end
    endtask

    task automatic test_p5_p6();
        do_reset();
        hi = 3;
        lo = 2;
        drive(10);
        checks++;
        if (bus.period !== 12'd5 || bus.high_cnt !== 12'd3 ||
            bus.stable !== 1'b0) begin
            errors++;
            $display("FAIL p5_first: got %0d/%0d st %0b want 5/3 st 0",
                     bus.period, bus.high_cnt, bus.stable);
        end
        drive(5);
        checks++;
        if (stb_n !== 2 || bus.stable !== 1'b1) begin
            errors++;
            $display("FAIL p5_stable: stb %0d stable %0b want 2 1",
                     stb_n, bus.stable);
        end
        hi = 3;
        lo = 3;
        drive(9);
        checks++;
        if (bus.period !== 12'd6 || bus.high_cnt !== 12'd3 ||
            bus.stable !== 1'b0) begin
            errors++;
            $display("FAIL p6_first: got %0d/%0d st %0b want 6/3 st 0",
                     bus.period, bus.high_cnt, bus.stable);
        end
        drive(6);
        checks++;
        if (bus.period !== 12'd6 || bus.stable !== 1'b1 || stb_n !== 5) begin
            errors++;
            $display("FAIL p6_stable: per %0d st %0b stb %0d want 6 1 5",
                     bus.period, bus.stable, stb_n);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        hi = 8;
        lo = 8;
        drive(35);
        checks++;
        if (bus.period !== 12'd16 || bus.high_cnt !== 12'd8 ||
            bus.timeout !== 1'b0 || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL to_p16: per %0d hi %0d to %0b v %0b want 16 8 0 1",
                     bus.period, bus.high_cnt, bus.timeout, bus.valid);
        end
        hi = 8;
        lo = 9;
        drive(17);
        checks++;
        if (bus.timeout !== 1'b1 || bus.valid !== 1'b0 ||
            bus.stable !== 1'b0) begin
            errors++;
            $display("FAIL to_p17: to %0b v %0b st %0b want 1 0 0",
                     bus.timeout, bus.valid, bus.stable);
        end
        checks++;
        if (to_tick - stb_tick !== 16) begin
            errors++;
            $display("FAIL to_delay: got %0d want 16", to_tick - stb_tick);
        end
        checks++;
        if (bus.period !== 12'd16 || stb_n !== 2) begin
            errors++;
            $display("FAIL to_hold: per %0d stb %0d want 16 2",
                     bus.period, stb_n);
        end
        hi = 4;
        lo = 4;
        drive(7);
        checks++;
        if (bus.timeout !== 1'b1 || stb_n !== 2) begin
            errors++;
            $display("FAIL to_sticky: to %0b stb %0d want 1 2",
                     bus.timeout, stb_n);
        end
        drive(1);
        checks++;
        if (stb_n !== 3 || bus.timeout !== 1'b0 || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL to_clear: stb %0d to %0b v %0b want 3 0 1",
                     stb_n, bus.timeout, bus.valid);
        end
        checks++;
        if (bus.period !== 12'd8 || bus.high_cnt !== 12'd4) begin
            errors++;
            $display("FAIL to_resume: got %0d/%0d want 8/4",
                     bus.period, bus.high_cnt);
        end
    endtask

    task automatic test_enable();
        do_reset();
        hi = 4;
        lo = 4;
        drive(32);
        checks++;
        if (stb_n !== 3 || bus.period !== 12'd8 || bus.stable !== 1'b1) begin
            errors++;
            $display("FAIL en_pre: stb %0d per %0d st %0b want 3 8 1",
                     stb_n, bus.period, bus.stable);
        end
        drive(2);
        bus.en = 1'b0;
        drive(10);
        checks++;
        if (bus.valid !== 1'b0 || bus.stable !== 1'b0) begin
            errors++;
            $display("FAIL en_off: v %0b st %0b want 0 0",
                     bus.valid, bus.stable);
        end
        checks++;
        if (bus.period !== 12'd8 || stb_n !== 3) begin
            errors++;
            $display("FAIL en_hold: per %0d stb %0d want 8 3",
                     bus.period, stb_n);
        end
        bus.en = 1'b1;
        drive(14);
        checks++;
        if (stb_n !== 3 || bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL en_one_edge: stb %0d v %0b want 3 0",
                     stb_n, bus.valid);
        end
        drive(1);
        checks++;
        if (stb_n !== 4 || bus.period !== 12'd8 || bus.stable !== 1'b0 ||
            bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL en_resume: stb %0d per %0d st %0b v %0b want 4 8 0 1",
                     stb_n, bus.period, bus.stable, bus.valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        hi = 3;
        lo = 3;
        drive(22);
        checks++;
        if (stb_n !== 3 || bus.period !== 12'd6 || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre: stb %0d per %0d v %0b want 3 6 1",
                     stb_n, bus.period, bus.valid);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.period !== 12'd0 || bus.high_cnt !== 12'd0) begin
            errors++;
            $display("FAIL ar_counts: got %0d/%0d want 0/0",
                     bus.period, bus.high_cnt);
        end
        checks++;
        if (bus.valid !== 1'b0 || bus.stable !== 1'b0 ||
            bus.meas_stb !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL ar_flags: v %0b st %0b stb %0b to %0b want 0",
                     bus.valid, bus.stable, bus.meas_stb, bus.timeout);
        end
        #2 rst_n = 1'b1;
        stb_n = 0;
        drive(10);
        checks++;
        if (stb_n !== 0 || bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL ar_one_edge: stb %0d v %0b want 0 0",
                     stb_n, bus.valid);
        end
        drive(1);
        checks++;
        if (stb_n !== 1 || bus.period !== 12'd6 || bus.high_cnt !== 12'd3 ||
            bus.stable !== 1'b0) begin
            errors++;
            $display("FAIL ar_recover: stb %0d %0d/%0d st %0b want 1 6/3 0",
                     stb_n, bus.period, bus.high_cnt, bus.stable);
        end
    endtask

    task automatic test_stb_width();
        checks++;
        if (dbl !== 0) begin
            errors++;
            $display("FAIL stb_width: %0d back-to-back pulses want 0", dbl);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b1;
        bus.sig_in = 1'b0;
        test_reset();
        test_div4();
        test_p5_p6();
        test_timeout();
        test_enable();
        test_async_reset();
        test_stb_width();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
